// File: rtl/cfe_pkg.sv
// Shared widths, FSM state type and signed saturation helper for the CFE feedback timer.
package cfe_pkg;

  localparam int CFE_NBW_FO  = 13;
  localparam int CFE_NBW_LAT = 32;
  localparam int CFE_NBW_ACC = 16;

  // Working width of the saturation helper; callers sign-extend into it and truncate back.
  localparam int CFE_SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WAIT  = 2'd2
  } cfe_state_t;

  // Clamp v to the signed range of a w-bit two's-complement word.
  function automatic logic signed [CFE_SAT_W-1:0] cfe_sat(
    input logic signed [CFE_SAT_W-1:0] v,
    input int unsigned                 w
  );
    logic signed [CFE_SAT_W-1:0] hi;
    logic signed [CFE_SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/cfe_sat_sub.sv
// Combinational res = sat(acc - sext(fo)); one guard bit keeps negating the most negative fo exact.
module cfe_sat_sub
  import cfe_pkg::*;
#(
  parameter int NBW_FO  = cfe_pkg::CFE_NBW_FO,
  parameter int NBW_ACC = cfe_pkg::CFE_NBW_ACC
) (
  input  logic signed [NBW_ACC-1:0] acc,
  input  logic signed [NBW_FO-1:0]  fo,
  output logic signed [NBW_ACC-1:0] res
);

  logic signed [NBW_ACC:0]   acc_x;
  logic signed [NBW_ACC:0]   fo_x;
  logic signed [NBW_ACC:0]   diff;
  logic signed [CFE_SAT_W-1:0] diff_w;

  assign acc_x  = {acc[NBW_ACC-1], acc};
  assign fo_x   = {{(NBW_ACC + 1 - NBW_FO){fo[NBW_FO-1]}}, fo};
  assign diff   = acc_x - fo_x;
  assign diff_w = {{(CFE_SAT_W - NBW_ACC - 1){diff[NBW_ACC]}}, diff};
  assign res    = NBW_ACC'(cfe_sat(diff_w, NBW_ACC));

endmodule

// File: rtl/cfe_feedback_timer.sv
// Applies each accepted offset estimate as a negated saturating step to the NCO correction, then blanks for max(i_wait,1) cycles.
// o_ready is high only in ARMED; o_corr_valid pulses the cycle after acceptance. Macro CFE_FB_TIMER_STATS_EN enables o_blank_cnt.
module cfe_feedback_timer
  import cfe_pkg::*;
#(
  parameter int NBW_FO  = cfe_pkg::CFE_NBW_FO,
  parameter int NBW_LAT = cfe_pkg::CFE_NBW_LAT,
  parameter int NBW_ACC = cfe_pkg::CFE_NBW_ACC
) (
  input  logic                      clk,
  input  logic                      rst_async_n,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic signed [NBW_FO-1:0]  i_fo_value,
  input  logic [NBW_LAT-1:0]        i_wait,
  output logic                      o_ready,
  output logic signed [NBW_ACC-1:0] o_fo_corr,
  output logic                      o_corr_valid,
  output logic [15:0]               o_blank_cnt
);

  cfe_state_t               state;
  cfe_state_t               state_nxt;
  logic [NBW_LAT-1:0]       cnt;
  logic [NBW_LAT-1:0]       cnt_nxt;
  logic                     accept;
  logic signed [NBW_ACC-1:0] corr_sat;

  cfe_sat_sub #(
    .NBW_FO  (NBW_FO),
    .NBW_ACC (NBW_ACC)
  ) u_sat_sub (
    .acc (o_fo_corr),
    .fo  (i_fo_value),
    .res (corr_sat)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) state_nxt = ARMED;
      end
      ARMED: begin
        if (!i_enable) begin
          state_nxt = IDLE;
        end else if (i_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
          // A zero wait still blanks one cycle so the step reaches the NCO first.
          cnt_nxt   = (i_wait == '0) ? NBW_LAT'(1) : i_wait;
        end
      end
      WAIT: begin
        if (!i_enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt <= NBW_LAT'(1)) begin
          state_nxt = ARMED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - NBW_LAT'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state        <= IDLE;
      cnt          <= '0;
      o_fo_corr    <= '0;
      o_corr_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      o_corr_valid <= accept;
      if (accept) o_fo_corr <= corr_sat;
    end
  end

  assign o_ready = (state == ARMED);

`ifdef CFE_FB_TIMER_STATS_EN
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      o_blank_cnt <= '0;
    end else if ((state == WAIT) && i_valid && i_enable && (o_blank_cnt != 16'hFFFF)) begin
      o_blank_cnt <= o_blank_cnt + 16'd1;
    end
  end
`else
  assign o_blank_cnt = '0;
`endif

endmodule

// File: tb/tb_cfe_feedback_timer.sv
// Directed bench: vector table for cycle-by-cycle cadence, plus hand sequences for saturation, disable, wait change and async reset.
module tb_cfe_feedback_timer;

  logic        clk;
  logic        rst_async_n;
  logic        i_enable;
  logic        i_valid;
  logic [12:0] i_fo_value;
  logic [31:0] i_wait;
  logic        o_ready;
  logic [15:0] o_fo_corr;
  logic        o_corr_valid;
  logic [15:0] o_blank_cnt;

  int checks;
  int failures;

  cfe_feedback_timer dut (
    .clk          (clk),
    .rst_async_n  (rst_async_n),
    .i_enable     (i_enable),
    .i_valid      (i_valid),
    .i_fo_value   (i_fo_value),
    .i_wait       (i_wait),
    .o_ready      (o_ready),
    .o_fo_corr    (o_fo_corr),
    .o_corr_valid (o_corr_valid),
    .o_blank_cnt  (o_blank_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic        en;
    logic        vld;
    logic [12:0] fo;
    logic [31:0] wt;
    logic        exp_rdy;
    logic [15:0] exp_corr;
    logic        exp_cv;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rb, input logic en, input logic vld, input logic [12:0] fo,
                     input logic [31:0] wt, input logic r, input logic [15:0] c, input logic v);
    vec_t x;
    x.rst_before = rb; x.en = en; x.vld = vld; x.fo = fo; x.wt = wt;
    x.exp_rdy = r; x.exp_corr = c; x.exp_cv = v;
    vq.push_back(x);
  endtask

  task automatic do_reset();
    i_enable = 1'b0;
    i_valid  = 1'b0;
    @(negedge clk);
    rst_async_n = 1'b0;
    @(negedge clk);
    rst_async_n = 1'b1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n_acc;
    int exp_i;
    int low_cycles;
    logic [15:0] exp_blank;

    checks = 0; failures = 0;
    i_enable = 1'b0; i_valid = 1'b0; i_fo_value = '0; i_wait = '0;
    rst_async_n = 1'b0;
    #1;
    chk("reset_ready", {31'd0, o_ready}, 32'd0);
    chk("reset_corr", {16'd0, o_fo_corr}, 32'd0);
    chk("reset_cv", {31'd0, o_corr_valid}, 32'd0);
    chk("reset_blank", {16'd0, o_blank_cnt}, 32'd0);
    @(negedge clk);
    rst_async_n = 1'b1;

    // Basic cadence, W=4, fo=+32; first vector shows IDLE ignores i_valid.
    add(1, 0, 1, 13'h0020, 4, 0, 16'h0000, 0);
    add(0, 1, 1, 13'h0020, 4, 1, 16'h0000, 0);
    add(0, 1, 1, 13'h0020, 4, 0, 16'hFFE0, 1);
    add(0, 1, 1, 13'h0020, 4, 0, 16'hFFE0, 0);
    add(0, 1, 1, 13'h0020, 4, 0, 16'hFFE0, 0);
    add(0, 1, 1, 13'h0020, 4, 0, 16'hFFE0, 0);
    add(0, 1, 1, 13'h0020, 4, 1, 16'hFFE0, 0);
    add(0, 1, 1, 13'h0020, 4, 0, 16'hFFC0, 1);
    add(0, 1, 1, 13'h0020, 4, 0, 16'hFFC0, 0);
    add(0, 1, 1, 13'h0020, 4, 0, 16'hFFC0, 0);
    add(0, 1, 1, 13'h0020, 4, 0, 16'hFFC0, 0);
    add(0, 1, 1, 13'h0020, 4, 1, 16'hFFC0, 0);
    add(0, 1, 1, 13'h0020, 4, 0, 16'hFFA0, 1);
    // Zero wait, fo=-1: accepts every other edge; then enable beats valid in ARMED.
    add(1, 1, 1, 13'h1FFF, 0, 1, 16'h0000, 0);
    add(0, 1, 1, 13'h1FFF, 0, 0, 16'h0001, 1);
    add(0, 1, 1, 13'h1FFF, 0, 1, 16'h0001, 0);
    add(0, 1, 1, 13'h1FFF, 0, 0, 16'h0002, 1);
    add(0, 1, 1, 13'h1FFF, 0, 1, 16'h0002, 0);
    add(0, 1, 1, 13'h1FFF, 0, 0, 16'h0003, 1);
    add(0, 1, 1, 13'h1FFF, 0, 1, 16'h0003, 0);
    add(0, 0, 1, 13'h1FFF, 0, 0, 16'h0003, 0);

`ifdef CFE_FB_TIMER_STATS_EN
    exp_blank = 16'd8;
`else
    exp_blank = 16'd0;
`endif

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst_before) do_reset();
      i_enable   = vq[i].en;
      i_valid    = vq[i].vld;
      i_fo_value = vq[i].fo;
      i_wait     = vq[i].wt;
      edge_step();
      chk($sformatf("vec%0d_ready", i), {31'd0, o_ready}, {31'd0, vq[i].exp_rdy});
      chk($sformatf("vec%0d_corr", i), {16'd0, o_fo_corr}, {16'd0, vq[i].exp_corr});
      chk($sformatf("vec%0d_cv", i), {31'd0, o_corr_valid}, {31'd0, vq[i].exp_cv});
      if (i == 12) chk("basic_blank_cnt", {16'd0, o_blank_cnt}, {16'd0, exp_blank});
    end

    // Saturation: fo=-4096 each accept, W=1 -> accepts at edges 2,4,...,20.
    do_reset();
    i_enable = 1'b1; i_valid = 1'b1; i_fo_value = 13'h1000; i_wait = 32'd1;
    n_acc = 0;
    for (int e = 1; e <= 20; e++) begin
      edge_step();
      if (o_corr_valid) begin
        n_acc++;
        exp_i = n_acc * 4096;
        if (exp_i > 32767) exp_i = 32767;
        chk($sformatf("sat_acc%0d", n_acc), {16'd0, o_fo_corr}, exp_i);
      end
    end
    chk("sat_accept_count", n_acc, 32'd10);

    // Disable mid-WAIT, re-enable, accept without waiting out the counter.
    do_reset();
    i_enable = 1'b1; i_valid = 1'b1; i_fo_value = 13'h0010; i_wait = 32'd100;
    edge_step();
    edge_step();
    chk("dis_first_corr", {16'd0, o_fo_corr}, 32'h0000FFF0);
    for (int e = 0; e < 10; e++) edge_step();
    chk("dis_still_wait", {31'd0, o_ready}, 32'd0);
    i_enable = 1'b0;
    edge_step();
    chk("dis_idle_ready", {31'd0, o_ready}, 32'd0);
    chk("dis_corr_held", {16'd0, o_fo_corr}, 32'h0000FFF0);
    i_enable = 1'b1;
    edge_step();
    chk("dis_rearm_ready", {31'd0, o_ready}, 32'd1);
    chk("dis_rearm_cv", {31'd0, o_corr_valid}, 32'd0);
    edge_step();
    chk("dis_reaccept_corr", {16'd0, o_fo_corr}, 32'h0000FFE0);
    chk("dis_reaccept_cv", {31'd0, o_corr_valid}, 32'd1);

    // Wait sampled only at acceptance: W=8 then changed to 2 during blanking.
    do_reset();
    i_enable = 1'b1; i_valid = 1'b1; i_fo_value = 13'h0001; i_wait = 32'd8;
    edge_step();
    edge_step();
    chk("wchg_accept_cv", {31'd0, o_corr_valid}, 32'd1);
    i_wait = 32'd2;
    low_cycles = 1;
    for (int e = 0; e < 30 && !o_ready; e++) begin
      edge_step();
      if (!o_ready) low_cycles++;
    end
    chk("wchg_rearmed", {31'd0, o_ready}, 32'd1);
    chk("wchg_blank_len", low_cycles, 32'd8);

    // Asynchronous reset asserted between edges while in WAIT.
    do_reset();
    i_enable = 1'b1; i_valid = 1'b1; i_fo_value = 13'h0020; i_wait = 32'd50;
    for (int e = 0; e < 5; e++) edge_step();
    chk("arst_pre_corr", {16'd0, o_fo_corr}, 32'h0000FFE0);
    #2;
    rst_async_n = 1'b0;
    #1;
    chk("arst_corr", {16'd0, o_fo_corr}, 32'd0);
    chk("arst_ready", {31'd0, o_ready}, 32'd0);
    chk("arst_blank", {16'd0, o_blank_cnt}, 32'd0);
    chk("arst_cv", {31'd0, o_corr_valid}, 32'd0);
    @(negedge clk);
    rst_async_n = 1'b1;
    edge_step();
    chk("arst_restart_ready", {31'd0, o_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
